// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with full/almostfull throttling and per-write completion.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fifo_wr_arbiter #(
  parameter int unsigned  FIFO_WIDTH = 16,
  parameter int unsigned  N_REQ      = 4,
  localparam int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        fifo_full,
  input  logic                        fifo_almostfull,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic                        fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  output logic                        ack_vld,
  output logic [ID_W-1:0]             ack_id,
  output logic                        ack_ok,
  output logic [1:0]                  arb_state,
  output logic                        drop_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BLOCKED = 2'd2
  } state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    w_can_issue;
  logic                    w_found;
  logic                    w_grant;
  logic [ID_W-1:0]         w_winner;
  logic [FIFO_WIDTH-1:0]   w_win_data;
  logic                    r_wr_en;
  logic [FIFO_WIDTH-1:0]   r_data;
  logic [ID_W-1:0]         r_id1;
  logic [ID_W-1:0]         r_id2;
  logic                    r_v2;
  logic                    r_ack_vld;
  logic [ID_W-1:0]         r_ack_id;
  logic                    r_ack_ok;
  logic                    r_drop_err;
`ifndef FIFO_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]         r_ptr;
`endif

  // A write already in flight is not yet reflected in the flags, so almostfull must stall it.
  assign w_can_issue = !fifo_full && !(r_wr_en && fifo_almostfull);

  // Winner = requester with smallest priority distance (from ptr+1 with wrap, or plain index).
  always_comb begin : sel_comb
    int unsigned v_best;
    int unsigned v_dist;
    w_found    = 1'b0;
    w_winner   = '0;
    w_win_data = '0;
    v_best     = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      v_dist = 32'(i);
`else
      v_dist = (32'(i) + N_REQ - 32'd1 - 32'(r_ptr)) % N_REQ;
`endif
      if (req[i] && (v_dist < v_best)) begin
        v_best     = v_dist;
        w_found    = 1'b1;
        w_winner   = ID_W'(i);
        w_win_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  assign w_grant = w_found && w_can_issue;
  assign gnt     = w_grant ? (N_REQ'(1) << w_winner) : '0;

  // Issue stage and two-stage id pipeline aligned with the FIFO's registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en    <= 1'b0;
      r_data     <= '0;
      r_id1      <= '0;
      r_id2      <= '0;
      r_v2       <= 1'b0;
      r_ack_vld  <= 1'b0;
      r_ack_id   <= '0;
      r_ack_ok   <= 1'b0;
      r_drop_err <= 1'b0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      r_ptr      <= ID_W'(N_REQ - 1);
`endif
    end else begin
      r_wr_en   <= w_grant;
      if (w_grant) begin
        r_data <= w_win_data;
        r_id1  <= w_winner;
`ifndef FIFO_ARB_FIXED_PRIO_EN
        r_ptr  <= w_winner;
`endif
      end
      r_id2     <= r_id1;
      r_v2      <= r_wr_en;
      r_ack_vld <= r_v2;
      if (r_v2) begin
        r_ack_id <= r_id2;
        r_ack_ok <= fifo_wr_ack && !fifo_overflow;
        if (!fifo_wr_ack || fifo_overflow) begin
          r_drop_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (req == '0) begin
      w_state_nxt = S_IDLE;
    end else if (w_grant) begin
      w_state_nxt = S_ISSUE;
    end else begin
      w_state_nxt = S_BLOCKED;
    end
  end

  always_comb begin
    arb_state = 2'(r_state);
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign ack_vld      = r_ack_vld;
  assign ack_id       = r_ack_id;
  assign ack_ok       = r_ack_ok;
  assign drop_err     = r_drop_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-8 behavioural FIFO write side.
module tb_fifo_wr_arbiter;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int DEPTH = 8;
`ifdef FIFO_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           ack_vld;
  logic [1:0]     ack_id;
  logic           ack_ok;
  logic [1:0]     arb_state;
  logic           drop_err;

  logic rd;
  logic force_drop;
  int   cnt;
  logic m_ack, m_ov, ov_seen;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .ack_vld(ack_vld), .ack_id(ack_id), .ack_ok(ack_ok),
    .arb_state(arb_state), .drop_err(drop_err)
  );

  // Behavioural FIFO occupancy and registered write response.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 0;
      m_ack   <= 1'b0;
      m_ov    <= 1'b0;
      ov_seen <= 1'b0;
    end else begin
      m_ack   <= fifo_wr_en && (cnt < DEPTH);
      m_ov    <= fifo_wr_en && (cnt >= DEPTH);
      cnt     <= cnt + ((fifo_wr_en && cnt < DEPTH) ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
      if (m_ov) ov_seen <= 1'b1;
    end
  end

  assign fifo_full       = (cnt == DEPTH);
  assign fifo_almostfull = (cnt >= DEPTH - 1);
  assign fifo_wr_ack     = force_drop ? 1'b0 : m_ack;
  assign fifo_overflow   = force_drop ? 1'b1 : m_ov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req        = '0;
    rd         = 1'b0;
    force_drop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Expected grant id in cycle t of the all-request run: 8 grants, then the throttle holds.
  function automatic int gid(input int t);
    if (t < 0 || t > 7) return -1;
    return FIXED ? 0 : (t % 4);
  endfunction

  initial begin
    int g, gp, ga, ngr;
    logic seen;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'(16'hA0 + i);

    // Reset values
    rst_n = 1'b0; req = '0; rd = 1'b0; force_drop = 1'b0;
    #2;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data_in", 32'(fifo_data_in), 32'd0);
    chk("rst_ack_vld", 32'(ack_vld), 32'd0);
    chk("rst_ack_id", 32'(ack_id), 32'd0);
    chk("rst_ack_ok", 32'(ack_ok), 32'd0);
    chk("rst_state", 32'(arb_state), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);

    // All four requesting: rotation, data order, 3-cycle completion, then throttle
    do_reset();
    req = 4'b1111;
    #1;
    for (int t = 0; t < 12; t++) begin
      if (t > 0) cyc();
      g  = gid(t);
      gp = gid(t - 1);
      ga = gid(t - 3);
      chk("rr_gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("rr_wr_en", 32'(fifo_wr_en), (gp >= 0) ? 32'd1 : 32'd0);
      if (gp >= 0) chk("rr_data_in", 32'(fifo_data_in), 32'(32'hA0 + gp));
      chk("rr_ack_vld", 32'(ack_vld), (ga >= 0) ? 32'd1 : 32'd0);
      if (ga >= 0) begin
        chk("rr_ack_id", 32'(ack_id), 32'(ga));
        chk("rr_ack_ok", 32'(ack_ok), 32'd1);
      end
      chk("rr_state", 32'(arb_state), (t == 0) ? 32'd0 : ((gp >= 0) ? 32'd1 : 32'd2));
    end

    // Single requester fills depth-8 FIFO, then one read admits exactly one more write
    do_reset();
    req = 4'b0001;
    #1;
    ngr = 0;
    for (int t = 0; t < 16; t++) begin
      if (gnt != '0) ngr++;
      cyc();
    end
    chk("fill_grants", 32'(ngr), 32'd8);
    chk("fill_gnt", 32'(gnt), 32'd0);
    chk("fill_state", 32'(arb_state), 32'd2);
    chk("fill_full", 32'(fifo_full), 32'd1);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    ngr = 0;
    for (int t = 0; t < 6; t++) begin
      if (gnt != '0) ngr++;
      cyc();
    end
    chk("read_one_grant", 32'(ngr), 32'd1);
    chk("fill_overflow", 32'(ov_seen), 32'd0);
    chk("fill_drop_err", 32'(drop_err), 32'd0);

    // Dropped write: forced bad response, sticky drop_err
    do_reset();
    req = 4'b0100;
    #1;
    chk("drop_gnt", 32'(gnt), 32'b0100);
    cyc();
    req = '0;
    chk("drop_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("drop_data", 32'(fifo_data_in), 32'hA2);
    cyc();
    force_drop = 1'b1;
    chk("drop_early_ack", 32'(ack_vld), 32'd0);
    cyc();
    force_drop = 1'b0;
    chk("drop_ack_vld", 32'(ack_vld), 32'd1);
    chk("drop_ack_id", 32'(ack_id), 32'd2);
    chk("drop_ack_ok", 32'(ack_ok), 32'd0);
    chk("drop_err_set", 32'(drop_err), 32'd1);
    req = 4'b0001;
    #1;
    chk("drop_next_gnt", 32'(gnt), 32'b0001);
    cyc();
    req = '0;
    chk("drop_pulse_end", 32'(ack_vld), 32'd0);
    cyc();
    cyc();
    chk("good_ack_vld", 32'(ack_vld), 32'd1);
    chk("good_ack_id", 32'(ack_id), 32'd0);
    chk("good_ack_ok", 32'(ack_ok), 32'd1);
    chk("drop_err_sticky", 32'(drop_err), 32'd1);
    cyc();
    chk("good_pulse_end", 32'(ack_vld), 32'd0);

    // Reset one cycle after a grant aborts the in-flight write
    do_reset();
    req = 4'b0010;
    #1;
    chk("abort_gnt", 32'(gnt), 32'b0010);
    cyc();
    chk("abort_wr_en_pre", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("abort_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("abort_ack_vld", 32'(ack_vld), 32'd0);
    chk("abort_state", 32'(arb_state), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 5; t++) begin
      cyc();
      if (ack_vld) seen = 1'b1;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    chk("abort_drop_err", 32'(drop_err), 32'd0);
    req = 4'b1111;
    #1;
    chk("abort_first_gnt", 32'(gnt), 32'b0001);

    // Two non-adjacent-to-zero requesters held
    do_reset();
    req = 4'b0110;
    #1;
    for (int t = 0; t < 6; t++) begin
      if (t > 0) cyc();
      chk("pair_gnt", 32'(gnt), (FIXED || (t % 2 == 0)) ? 32'b0010 : 32'b0100);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
